// File: rtl/ir_sample_seq.sv
// IR sample sequencer: periodically fires the IR emitters, waits for the
// sensors to settle, runs 8 A2D conversions (channels 0..7) and latches the
// results into a small register file read through rd_sel/rd_data.
module ir_sample_seq #(
    parameter int PERIOD  = 4096,
    parameter int SETTLE  = 256,
    parameter int TIMEOUT = 1024,
    parameter int DW      = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          a2d_cmplt,
    input  logic [DW-1:0] a2d_res,
    input  logic [2:0]    rd_sel,
    output logic          a2d_strt,
    output logic [2:0]    chnl,
    output logic          IR_en,
    output logic          IR_vld,
    output logic [DW-1:0] rd_data,
    output logic          ovr,
    output logic          a2d_to
);

    localparam int TW  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int SCW = $clog2(SETTLE + 1);
    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [TW-1:0]  TMR_LAST    = TW'(PERIOD - 1);
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE - 1);
    localparam logic [WCW-1:0] WAIT_LAST   = WCW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          state, state_d;
    logic [TW-1:0]   timer;
    logic            tick;
    logic [2:0]      ch, ch_d;
    logic [SCW-1:0]  settle_cnt, settle_d;
    logic [WCW-1:0]  wait_cnt, wait_d;
    logic            to_q, to_d;
    logic            store;
    logic [DW-1:0]   readings [8];

    assign tick = (timer == TMR_LAST);

    // Free-running scan interval timer, independent of en and FSM state
    always_ff @(posedge clk) begin
        if (rst)
            timer <= '0;
        else if (tick)
            timer <= '0;
        else
            timer <= timer + 1'b1;
    end

    // FSM state and scan bookkeeping registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            ch         <= '0;
            settle_cnt <= '0;
            wait_cnt   <= '0;
            to_q       <= 1'b0;
        end else begin
            state      <= state_d;
            ch         <= ch_d;
            settle_cnt <= settle_d;
            wait_cnt   <= wait_d;
            to_q       <= to_d;
        end
    end

    // Reading register file: written only on a conversion accepted in WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 8; i++)
                readings[i] <= '0;
        end else if (store) begin
            readings[ch] <= a2d_res;
        end
    end

    // Next-state logic; a completion in the timeout cycle takes priority
    always_comb begin
        state_d  = state;
        ch_d     = ch;
        settle_d = settle_cnt;
        wait_d   = wait_cnt;
        to_d     = to_q;
        store    = 1'b0;
        case (state)
            S_IDLE: begin
                if (tick && en) begin
                    state_d  = S_SETTLE;
                    ch_d     = '0;
                    settle_d = '0;
                    to_d     = 1'b0;
                end
            end
            S_SETTLE: begin
                if (settle_cnt == SETTLE_LAST)
                    state_d = S_START;
                else
                    settle_d = settle_cnt + 1'b1;
            end
            S_START: begin
                state_d = S_WAIT;
                wait_d  = '0;
            end
            S_WAIT: begin
                if (a2d_cmplt) begin
                    store = 1'b1;
                    if (ch == 3'd7) begin
                        state_d = S_DONE;
                    end else begin
                        ch_d    = ch + 3'd1;
                        state_d = S_START;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    to_d    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_cnt + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state
    always_comb begin
        a2d_strt = (state == S_START);
        IR_en    = (state == S_SETTLE) || (state == S_START) || (state == S_WAIT);
        IR_vld   = (state == S_DONE);
        ovr      = tick && (state != S_IDLE);
        chnl     = ch;
        a2d_to   = to_q;
        rd_data  = readings[rd_sel];
    end

endmodule
